// File: rtl/rr_mux_reg.sv
// N-channel registered selector with valid/ready on every input and on the output.
// Fixed-select or round-robin grant feeds a single output register stage.
module rr_mux_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        selCh,
    input  logic [NUM_CH-1:0]       inValid,
    input  logic [NUM_CH*WIDTH-1:0] inData,
    output logic [NUM_CH-1:0]       inReady,
    output logic                    outValid,
    output logic [WIDTH-1:0]        outData,
    output logic [SEL_W-1:0]        outCh,
    input  logic                    outReady
);

    logic                  r_vld;
    logic [WIDTH-1:0]      r_data;
    logic [SEL_W-1:0]      r_ch;
    logic [SEL_W-1:0]      r_last;

    logic                  w_load;
    logic                  w_gnt_vld;
    logic [SEL_W-1:0]      w_gnt;
    logic [WIDTH-1:0]      w_data;
    logic [2*NUM_CH-1:0]   w_rot;
    int                    w_first;
    int                    w_start;

    assign w_load   = !r_vld || outReady;
    assign outValid = r_vld;
    assign outData  = r_data;
    assign outCh    = r_ch;

    // Round-robin: rotate requests so the channel after lastGrant sits at bit 0,
    // then take the lowest set bit.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_first   = 0;
        w_start   = (int'(r_last) + 1) % NUM_CH;
        w_rot     = {inValid, inValid} >> w_start;
        if (!mode) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(selCh) == i && inValid[i]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = SEL_W'(i);
                end
            end
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (w_rot[i]) begin
                    w_gnt_vld = 1'b1;
                    w_first   = i;
                end
            end
            w_gnt = SEL_W'((w_start + w_first) % NUM_CH);
        end
    end

    always_comb begin
        inReady = '0;
        w_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(w_gnt) == i) begin
                w_data     = inData[i*WIDTH +: WIDTH];
                inReady[i] = rstN && w_load && w_gnt_vld;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_ch   <= '0;
            r_last <= SEL_W'(NUM_CH - 1);
        end else if (w_load) begin
            if (w_gnt_vld) begin
                r_vld  <= 1'b1;
                r_data <= w_data;
                r_ch   <= w_gnt;
                r_last <= w_gnt;
            end else begin
                r_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Scoreboard bench: a reference model predicts grants and pushes expected words,
// a monitor pops and compares whenever the output register presents a word.
module tb_rr_mux_reg;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rstN;
    logic          mode;
    logic [1:0]    selCh;
    logic [3:0]    inValid;
    logic [4*W-1:0] inData;
    logic [3:0]    inReady;
    logic          outValid;
    logic [W-1:0]  outData;
    logic [1:0]    outCh;
    logic          outReady;

    // three-channel instance for the out-of-range select case
    logic          mode3;
    logic [1:0]    selCh3;
    logic [2:0]    inValid3;
    logic [23:0]   inData3;
    logic [2:0]    inReady3;
    logic          outValid3;
    logic [7:0]    outData3;
    logic [1:0]    outCh3;
    logic          outReady3;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [W-1:0] d; int ch; } exp_t;
    exp_t q[$];
    bit   mv;
    int   mlast;

    always #5 clk = ~clk;

    rr_mux_reg #(.WIDTH(W), .NUM_CH(4), .SEL_W(2)) dut (
        .clk(clk), .rstN(rstN), .mode(mode), .selCh(selCh), .inValid(inValid),
        .inData(inData), .inReady(inReady), .outValid(outValid), .outData(outData),
        .outCh(outCh), .outReady(outReady)
    );

    rr_mux_reg #(.WIDTH(8), .NUM_CH(3), .SEL_W(2)) dut3 (
        .clk(clk), .rstN(rstN), .mode(mode3), .selCh(selCh3), .inValid(inValid3),
        .inData(inData3), .inReady(inReady3), .outValid(outValid3), .outData(outData3),
        .outCh(outCh3), .outReady(outReady3)
    );

    function automatic logic [W-1:0] chdata(int c);
        logic [4*W-1:0] v;
        v = inData;
        return v[c*W +: W];
    endfunction

    // Reference model: decides who should win this cycle from the rules alone.
    always @(negedge clk) begin
        int         g;
        bit         gv;
        bit         load;
        logic [3:0] er;
        if (rstN) begin
            checks++;
            if (outValid !== mv) begin
                errors++;
                $display("FAIL outValid t=%0t got %b want %b", $time, outValid, mv);
            end
            gv = 0; g = 0;
            if (!mode) begin
                if (int'(selCh) < 4 && inValid[selCh]) begin gv = 1; g = int'(selCh); end
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (mlast + k) % 4;
                    if (!gv && inValid[c]) begin gv = 1; g = c; end
                end
            end
            load = !mv || outReady;
            er = (load && gv) ? (4'b0001 << g) : 4'b0000;
            checks++;
            if (inReady !== er) begin
                errors++;
                $display("FAIL inReady t=%0t got %b want %b", $time, inReady, er);
            end
            if (load && gv) begin
                q.push_back('{d: chdata(g), ch: g});
                mv = 1; mlast = g;
            end else if (load) begin
                mv = 0;
            end
        end
    end

    // Monitor: every presented word must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rstN && outValid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected t=%0t got data %0d ch %0d", $time, outData, outCh);
            end else begin
                if (outData !== q[0].d || int'(outCh) != q[0].ch) begin
                    errors++;
                    $display("FAIL word t=%0t got data %0d ch %0d want data %0d ch %0d",
                             $time, outData, outCh, q[0].d, q[0].ch);
                end
                if (outReady) void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set4(input logic [31:0] d0, d1, d2, d3);
        inData = {d3, d2, d1, d0};
    endtask

    task automatic chk(input string name, input logic [31:0] got, want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, want);
        end
    endtask

    initial begin
        rstN = 1'b0; mode = 0; selCh = 0; inValid = 0; inData = '0; outReady = 1;
        mode3 = 0; selCh3 = 0; inValid3 = 0; inData3 = '0; outReady3 = 1;
        mv = 0; mlast = 3;
        step(); step();
        rstN = 1'b1;

        // idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_data", outData, 0);
            chk("idle_ch", 32'(outCh), 0);
            step();
        end

        // fixed mode
        set4(102, 15, 0, 0); inValid = 4'b0011; selCh = 1; step();
        selCh = 0; step();
        inValid = 0; step(); step();

        // round-robin fairness, then channel 1 drops out
        mode = 1; set4(53, 77, 200, 9); inValid = 4'b1111;
        for (int i = 0; i < 5; i++) step();
        inValid = 4'b1101;
        for (int i = 0; i < 4; i++) step();
        inValid = 0; step(); step();

        // backpressure: hold 77 while ch2 waits, then drain and load together
        mode = 0; selCh = 1; set4(0, 77, 300, 0); inValid = 4'b0010; step();
        outReady = 0; selCh = 2; inValid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_data", outData, 77);
            chk("bp_ready", 32'(inReady), 0);
            step();
        end
        outReady = 1; step();
        @(negedge clk); chk("bp_load", outData, 300);
        inValid = 0; step(); step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            mode     = 1'($urandom_range(0, 1));
            selCh    = 2'($urandom_range(0, 3));
            inValid  = 4'($urandom_range(0, 15));
            set4($urandom, $urandom, $urandom, $urandom);
            outReady = ($urandom_range(0, 9) < 7);
            step();
        end

        // reset mid-operation with a held word
        mode = 0; selCh = 3; set4(0, 0, 0, 555); inValid = 4'b1000; outReady = 1; step();
        outReady = 0; inValid = 0; step();
        @(posedge clk); #1;
        rstN = 1'b0; #1;
        chk("rst_async_vld", 32'(outValid), 0);
        chk("rst_ready", 32'(inReady), 0);
        #2;
        mv = 0; mlast = 3; q.delete();
        rstN = 1'b1;
        outReady = 1; mode = 1; set4(11, 22, 33, 44); inValid = 4'b1111; step();
        @(negedge clk); chk("rst_rr_first", 32'(outCh), 0);
        step(); step();
        inValid = 0; step(); step();

        // out-of-range select on the three-channel instance
        inData3 = {8'd30, 8'd20, 8'd10}; inValid3 = 3'b111; selCh3 = 0;
        @(negedge clk); chk("oor_pre_ready", 32'(inReady3), 1);
        step(); selCh3 = 3;
        @(negedge clk);
        chk("oor_ready", 32'(inReady3), 0);
        chk("oor_hold_vld", 32'(outValid3), 1);
        chk("oor_hold_data", 32'(outData3), 10);
        step();
        @(negedge clk);
        chk("oor_drained", 32'(outValid3), 0);
        chk("oor_ready2", 32'(inReady3), 0);
        step();

        if (q.size() > 1) begin
            errors++;
            $display("FAIL leftover_words got %0d want at most 1", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
